// File: rtl/decoder_queue_if.sv
// Handshake bundle for decoder_queue: producer-side instruction stream plus consumer-side decoded head.
// DECODER_PARITY_EN widens the instruction word by one even-parity bit.
interface decoder_queue_if #(
  parameter int NUM_W = 4,
  parameter int OP_W  = 2,
  parameter int DEPTH = 4
);
`ifdef DECODER_PARITY_EN
  localparam int IW = 2*NUM_W + OP_W + 2;
`else
  localparam int IW = 2*NUM_W + OP_W + 1;
`endif
  localparam int LW = $clog2(DEPTH) + 1;

  logic [IW-1:0]    instruct;
  logic             in_valid;
  logic             in_ready;
  logic [NUM_W-1:0] num1;
  logic [NUM_W-1:0] num2;
  logic [OP_W-1:0]  oper;
  logic             Ain;
  logic             out_valid;
  logic             out_ready;
  logic [LW-1:0]    level;
  logic             parity_err;

  modport master (
    output instruct, in_valid, out_ready,
    input  in_ready, num1, num2, oper, Ain, out_valid, level, parity_err
  );

  modport slave (
    input  instruct, in_valid, out_ready,
    output in_ready, num1, num2, oper, Ain, out_valid, level, parity_err
  );
endinterface

// File: rtl/decoder_queue.sv
// Instruction decoder with a DEPTH-entry FIFO between the link and the ALU/FSM side.
// DECODER_PARITY_EN: bit 0 carries even parity; odd words are dropped and flagged on parity_err.
module decoder_queue #(
  parameter int NUM_W = 4,
  parameter int OP_W  = 2,
  parameter int DEPTH = 4
) (
  input logic           clk,
  input logic           rst,
  decoder_queue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int EW = 2*NUM_W + OP_W + 1;
`ifdef DECODER_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int IW = EW + PB;

  logic [EW-1:0] fifo_mem [DEPTH];
  logic [PW-1:0] head_ptr;
  logic [PW-1:0] tail_ptr;
  logic [LW-1:0] level_q;
  logic [EW-1:0] head_entry;
  logic          in_ready;
  logic          out_valid;
  logic          push_hs;
  logic          word_ok;
  logic          push;
  logic          pop;

  // Handshake flags decode only from the registered level.
  assign in_ready  = (level_q != LW'(DEPTH));
  assign out_valid = (level_q != '0);
  assign push_hs   = bus.in_valid && in_ready;
  assign push      = push_hs && word_ok;
  assign pop       = out_valid && bus.out_ready;

`ifdef DECODER_PARITY_EN
  logic parity_err_q;

  function automatic logic parity_ok(input logic [IW-1:0] w);
    return ~(^w);
  endfunction

  assign word_ok = parity_ok(bus.instruct);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) parity_err_q <= 1'b0;
    else      parity_err_q <= push_hs && !word_ok;
  end

  assign bus.parity_err = parity_err_q;
`else
  assign word_ok        = 1'b1;
  assign bus.parity_err = 1'b0;
`endif

  // Control state: pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      level_q  <= '0;
    end else begin
      if (push) tail_ptr <= tail_ptr + PW'(1);
      if (pop)  head_ptr <= head_ptr + PW'(1);
      unique case ({push, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Storage holds the word minus its parity bit; contents are masked by out_valid.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[tail_ptr] <= bus.instruct[IW-1:PB];
  end

  assign head_entry    = fifo_mem[head_ptr];
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.level     = level_q;
  assign bus.num1      = out_valid ? head_entry[EW-1 -: NUM_W]       : '0;
  assign bus.num2      = out_valid ? head_entry[EW-1-NUM_W -: NUM_W] : '0;
  assign bus.oper      = out_valid ? head_entry[OP_W:1]              : '0;
  assign bus.Ain       = out_valid ? head_entry[0]                   : 1'b0;
endmodule

// File: tb/tb_decoder_queue.sv
// Randomised bench for decoder_queue: a queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_decoder_queue;
  localparam int NUM_W = 4;
  localparam int OP_W  = 2;
  localparam int DEPTH = 4;
`ifdef DECODER_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int IW = 2*NUM_W + OP_W + 1 + PB;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  decoder_queue_if #(.NUM_W(NUM_W), .OP_W(OP_W), .DEPTH(DEPTH)) bus();

  decoder_queue #(.NUM_W(NUM_W), .OP_W(OP_W), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  logic [IW-1:0] q[$];
  bit            exp_perr;
  bit            m_acc, m_ok, m_pop;
  int            sz;
  logic [63:0]   hv;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [IW-1:0] mk(input int n1, input int n2, input int op, input int a);
    logic [63:0] v;
    v = (64'(n1 & ((1 << NUM_W) - 1)) << (NUM_W + OP_W + 1)) |
        (64'(n2 & ((1 << NUM_W) - 1)) << (OP_W + 1)) |
        (64'(op & ((1 << OP_W) - 1)) << 1) |
        64'(a & 1);
    if (PB == 1) v = (v << 1) | 64'(^v);
    return v[IW-1:0];
  endfunction

  // Reference model: a queue of accepted words, updated on each rising edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      exp_perr = 1'b0;
    end else begin
      m_acc = bus.in_valid && (q.size() < DEPTH);
`ifdef DECODER_PARITY_EN
      m_ok = ((^bus.instruct) == 1'b0);
`else
      m_ok = 1'b1;
`endif
      m_pop = (q.size() > 0) && bus.out_ready;
      if (m_pop) void'(q.pop_front());
      if (m_acc && m_ok) q.push_back(bus.instruct);
      exp_perr = m_acc && !m_ok;
    end
  end

  // Every falling edge the DUT must present exactly the model's head and fill state.
  always @(negedge clk) begin
    if (cmp_en) begin
      sz = q.size();
      hv = (sz > 0) ? 64'(q[0]) : 64'd0;
      chk("level",      32'(bus.level),      32'(sz));
      chk("in_ready",   32'(bus.in_ready),   32'(sz < DEPTH));
      chk("out_valid",  32'(bus.out_valid),  32'(sz > 0));
      chk("num1",       32'(bus.num1),       32'((hv >> (PB + 1 + OP_W + NUM_W)) & ((64'd1 << NUM_W) - 1)));
      chk("num2",       32'(bus.num2),       32'((hv >> (PB + 1 + OP_W)) & ((64'd1 << NUM_W) - 1)));
      chk("oper",       32'(bus.oper),       32'((hv >> (PB + 1)) & ((64'd1 << OP_W) - 1)));
      chk("Ain",        32'(bus.Ain),        32'((hv >> PB) & 64'd1));
      chk("parity_err", 32'(bus.parity_err), 32'(exp_perr));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [IW-1:0] w;

  initial begin
    bus.instruct  = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    cmp_en = 1'b1;
    #1;
    chk("rst_level",     32'(bus.level),     32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;

    // Single push of 1010_0011_10_1
    bus.instruct = mk(4'hA, 4'h3, 2'b10, 1);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    chk("push_num1",  32'(bus.num1),      32'hA);
    chk("push_num2",  32'(bus.num2),      32'h3);
    chk("push_oper",  32'(bus.oper),      32'h2);
    chk("push_Ain",   32'(bus.Ain),       32'd1);
    chk("push_level", 32'(bus.level),     32'd1);
    chk("push_ovld",  32'(bus.out_valid), 32'd1);
    chk("model_size", 32'(q.size()),      32'd1);

    // Fill to full, then hold a fifth word until a pop frees a slot
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.instruct = mk(i + 1, 15 - i, i, i);
      tick();
    end
    bus.instruct = mk(4'h7, 4'h9, 2'b01, 0);
    tick();
    tick();
    chk("full_level",    32'(bus.level),    32'd4);
    chk("full_in_ready", 32'(bus.in_ready), 32'd0);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("after_pop_ready", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    chk("refill_level", 32'(bus.level), 32'd4);
    chk("head_order",   32'(bus.num1),  32'h1);

    // Drop to level 2, then push+pop together for ten cycles
    bus.out_ready = 1'b1;
    tick();
    tick();
    bus.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.instruct = mk($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 1));
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    chk("steady_level", 32'(bus.level), 32'd2);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      w = mk($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 1));
`ifdef DECODER_PARITY_EN
      if ($urandom_range(0, 7) == 0) w[0] = ~w[0];
`endif
      bus.instruct  = w;
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.out_ready = 1'($urandom_range(0, 1));
      tick();
    end

    // Drain to empty with out_ready kept high
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (DEPTH + 3) tick();
    chk("drain_ovld",  32'(bus.out_valid), 32'd0);
    chk("drain_num1",  32'(bus.num1),      32'd0);
    chk("drain_oper",  32'(bus.oper),      32'd0);
    chk("drain_Ain",   32'(bus.Ain),       32'd0);
    chk("drain_level", 32'(bus.level),     32'd0);
    bus.out_ready = 1'b0;

    // Asynchronous reset with three words stored
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.instruct = mk(i + 2, i + 4, 3, 1);
      tick();
    end
    bus.in_valid = 1'b0;
    chk("pre_rst_level", 32'(bus.level), 32'd3);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_level",    32'(bus.level),     32'd0);
    chk("arst_ovld",     32'(bus.out_valid), 32'd0);
    chk("arst_in_ready", 32'(bus.in_ready),  32'd1);
    chk("arst_num1",     32'(bus.num1),      32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    bus.instruct = mk(4'h5, 4'h6, 2'b01, 0);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    chk("post_rst_ovld",  32'(bus.out_valid), 32'd1);
    chk("post_rst_num1",  32'(bus.num1),      32'h5);
    chk("post_rst_num2",  32'(bus.num2),      32'h6);
    chk("post_rst_level", 32'(bus.level),     32'd1);

`ifdef DECODER_PARITY_EN
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    w = 12'b1010_0011_10_1_1;
    bus.instruct = w;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    chk("par_bad_err",   32'(bus.parity_err), 32'd1);
    chk("par_bad_level", 32'(bus.level),      32'd0);
    tick();
    chk("par_pulse_end", 32'(bus.parity_err), 32'd0);
    w = 12'b1010_0011_10_1_0;
    bus.instruct = w;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    chk("par_good_num1",  32'(bus.num1),  32'hA);
    chk("par_good_Ain",   32'(bus.Ain),   32'd1);
    chk("par_good_level", 32'(bus.level), 32'd1);
`endif

    tick();
    tick();
    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
